// File: rtl/legv8_pkg.sv
// legv8_pkg: LEGv8 encoding constants shared by the instruction encoder and
// the decode-side sign extender.
//   OP_LDUR / OP_STUR : 11-bit D-format opcodes (instr[31:21])
//   OP_CBZ            : 8-bit CB-format opcode (instr[31:24])
//   enc_op_t          : request opcode selector carried on in_op
//   DT_W / CB_W       : immediate field widths (DT_address, COND_BR_address)
package legv8_pkg;

  localparam int DT_W = 9;
  localparam int CB_W = 19;

  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;

  typedef enum logic [1:0] {
    ENC_LDUR = 2'b00,
    ENC_STUR = 2'b01,
    ENC_CBZ  = 2'b10,
    ENC_RSVD = 2'b11
  } enc_op_t;

  // A 64-bit value fits a DT_W-bit signed field when every bit from the
  // field's sign bit upward is identical.
  function automatic logic dt_fits(input logic [63:0] imm);
    return (&imm[63:DT_W-1]) | ~(|imm[63:DT_W-1]);
  endfunction

  function automatic logic cb_fits(input logic [63:0] imm);
    return (&imm[63:CB_W-1]) | ~(|imm[63:CB_W-1]);
  endfunction

  // Decode-side inverses: widen a field back to a 64-bit immediate.
  function automatic logic [63:0] dt_sext(input logic [DT_W-1:0] field);
    return {{(64-DT_W){field[DT_W-1]}}, field};
  endfunction

  function automatic logic [63:0] cb_sext(input logic [CB_W-1:0] field);
    return {{(64-CB_W){field[CB_W-1]}}, field};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request and instruction-word streams of instr_encoder.
//   in_valid/in_ready/in_op/in_rt/in_rn/in_imm   : symbolic request stream
//   out_valid/out_ready/out_instr/out_addr       : encoded word stream
//   range_err/wrapped                            : sticky status flags
// master = loader/consumer side, slave = encoder side.
interface instr_encoder_if #(parameter int ADDR_W = 6);

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [4:0]        in_rt;
  logic [4:0]        in_rn;
  logic [63:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              range_err;
  logic              wrapped;

  modport master (
    output in_valid, in_op, in_rt, in_rn, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, range_err, wrapped
  );

  modport slave (
    input  in_valid, in_op, in_rt, in_rn, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, range_err, wrapped
  );

endinterface

// File: rtl/instr_encoder_fifo2.sv
// fifo2: 2-entry in-order valid/ready FIFO built from a head and a tail
// register. All outputs come straight from registers: in_ready is
// (count<2) and out_valid is (count>0), both precomputed from next-count,
// so there is no combinational path from out_ready to in_ready.
// out_data reads zero while the FIFO is empty.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : push handshake, in_data is the pushed word
//   out_valid/out_ready   : pop handshake, out_data is the head word
module fifo2 #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   count_r;
  logic [1:0]   count_nxt_s;
  logic [W-1:0] head_r;
  logic [W-1:0] head_nxt_s;
  logic [W-1:0] tail_r;
  logic [W-1:0] tail_nxt_s;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         push_s;
  logic         pop_s;

  assign push_s = in_valid & in_ready_r;
  assign pop_s  = out_valid_r & out_ready;

  // Next-state of the two storage slots and the occupancy count.
  always_comb begin
    count_nxt_s = count_r;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    case ({push_s, pop_s})
      2'b10: begin
        if (count_r == 2'd0) begin
          head_nxt_s = in_data;
        end else begin
          tail_nxt_s = in_data;
        end
        count_nxt_s = count_r + 2'd1;
      end
      2'b01: begin
        // Tail advances into head; an emptied head is cleared so the
        // output reads zero while empty.
        if (count_r == 2'd2) begin
          head_nxt_s = tail_r;
        end else begin
          head_nxt_s = {W{1'b0}};
        end
        tail_nxt_s  = {W{1'b0}};
        count_nxt_s = count_r - 2'd1;
      end
      2'b11: begin
        // Only reachable at count 1 (no push at 2, no pop at 0):
        // the departing head is replaced by the new word.
        head_nxt_s = in_data;
      end
      default: begin
        count_nxt_s = count_r;
      end
    endcase
  end

  // Storage and registered handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r     <= 2'd0;
      head_r      <= {W{1'b0}};
      tail_r      <= {W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      head_r      <= head_nxt_s;
      tail_r      <= tail_nxt_s;
      in_ready_r  <= (count_nxt_s != 2'd2);
      out_valid_r <= (count_nxt_s != 2'd0);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = head_r;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming LEGv8 LDUR/STUR/CBZ encoder. Each request's
// immediate is range-checked against its instruction field and narrowed
// into it; legal words are pushed with a sequential word address into a
// 2-entry output FIFO. Illegal requests (out of range or reserved op) are
// consumed without output and set the sticky range_err flag.
//   clk, reset : clock, synchronous active-high reset
//   bus        : instr_encoder_if slave (request stream, word stream, flags)
module instr_encoder
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input logic              clk,
  input logic              reset,
  instr_encoder_if.slave   bus
);

  localparam int                DATA_W   = 32 + ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  enc_op_t           op_s;
  logic              legal_s;
  logic [31:0]       instr_s;
  logic              hs_s;
  logic              push_s;
  logic              fifo_push_valid_s;
  logic              fifo_in_ready_s;
  logic              fifo_out_valid_s;
  logic [DATA_W-1:0] fifo_out_data_s;
  logic [ADDR_W-1:0] addr_cnt_r;
  logic              range_err_r;
  logic              wrapped_r;

  // Encode the request and decide whether its immediate fits the field.
  always_comb begin
    op_s    = enc_op_t'(bus.in_op);
    legal_s = 1'b0;
    instr_s = 32'd0;
    case (op_s)
      ENC_LDUR: begin
        legal_s = dt_fits(bus.in_imm);
        instr_s = {OP_LDUR, bus.in_imm[DT_W-1:0], 2'b00, bus.in_rn, bus.in_rt};
      end
      ENC_STUR: begin
        legal_s = dt_fits(bus.in_imm);
        instr_s = {OP_STUR, bus.in_imm[DT_W-1:0], 2'b00, bus.in_rn, bus.in_rt};
      end
      ENC_CBZ: begin
        legal_s = cb_fits(bus.in_imm);
        instr_s = {OP_CBZ, bus.in_imm[CB_W-1:0], bus.in_rt};
      end
      default: begin
        legal_s = 1'b0;
        instr_s = 32'd0;
      end
    endcase
  end

  // Every offered request is consumed when the FIFO has room; only legal
  // ones are actually pushed.
  assign hs_s              = bus.in_valid & fifo_in_ready_s;
  assign push_s            = hs_s & legal_s;
  assign fifo_push_valid_s = bus.in_valid & legal_s;

  fifo2 #(
    .W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (fifo_push_valid_s),
    .in_ready  (fifo_in_ready_s),
    .in_data   ({instr_s, addr_cnt_r}),
    .out_valid (fifo_out_valid_s),
    .out_ready (bus.out_ready),
    .out_data  (fifo_out_data_s)
  );

  // Address counter and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_cnt_r  <= {ADDR_W{1'b0}};
      range_err_r <= 1'b0;
      wrapped_r   <= 1'b0;
    end else begin
      if (push_s) begin
        addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
        if (addr_cnt_r == ADDR_MAX) begin
          wrapped_r <= 1'b1;
        end
      end
      if (hs_s && !legal_s) begin
        range_err_r <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = fifo_in_ready_s;
  assign bus.out_valid = fifo_out_valid_s;
  assign bus.out_instr = fifo_out_data_s[DATA_W-1:ADDR_W];
  assign bus.out_addr  = fifo_out_data_s[ADDR_W-1:0];
  assign bus.range_err = range_err_r;
  assign bus.wrapped   = wrapped_r;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder with a
// 2-bit address counter so wrap-around is reached quickly.
module tb_instr_encoder;

  localparam int ADDR_W = 2;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [ADDR_W-1:0] exp_addr;

  logic [1:0]        r_op;
  logic [4:0]        r_rt;
  logic [4:0]        r_rn;
  longint            r_imm;
  longint            got;
  logic signed [8:0]  dt_f;
  logic signed [18:0] cb_f;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [4:0] rt, input logic [4:0] rn,
                       input longint imm);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rt    = rt;
    bus.in_rn    = rn;
    bus.in_imm   = imm;
  endtask

  // Offer a request, wait (bounded) for in_ready, complete the handshake.
  task automatic send(input logic [1:0] op, input logic [4:0] rt, input logic [4:0] rn,
                      input longint imm);
    drive(op, rt, rn, imm);
    for (int i = 0; i < 16 && !bus.in_ready; i++) tick();
    check("send_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // With out_ready high: word is at the head now and gone one cycle later.
  task automatic expect_word(input string tag, input logic [31:0] instr, input logic [ADDR_W-1:0] addr);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_instr"}, 64'(bus.out_instr), 64'(instr));
    check({tag, "_addr"},  64'(bus.out_addr),  64'(addr));
    tick();
    check({tag, "_drain"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
    exp_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op    = 2'b00;
    bus.in_rt    = 5'd0;
    bus.in_rn    = 5'd0;
    bus.in_imm   = 64'd0;
    bus.out_ready = 1'b1;

    // Reset state
    do_reset(2);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_range_err", 64'(bus.range_err), 64'd0);
    check("rst_wrapped",   64'(bus.wrapped),   64'd0);
    check("rst_out_instr", 64'(bus.out_instr), 64'd0);
    check("rst_out_addr",  64'(bus.out_addr),  64'd0);

    // Basic encodings with one-cycle latency
    send(2'b00, 5'd1, 5'd2, -64'sd8);
    expect_word("ldur_m8", 32'hF85F8041, 2'd0);
    send(2'b10, 5'd3, 5'd0, 64'sd5);
    expect_word("cbz_5", 32'hB40000A3, 2'd1);
    send(2'b10, 5'd0, 5'd0, -64'sd262144);
    expect_word("cbz_min", 32'hB4800000, 2'd2);
    check("pre_err_flag",  64'(bus.range_err), 64'd0);
    check("pre_wrap_flag", 64'(bus.wrapped),   64'd0);

    // CBZ just out of range is consumed and dropped
    send(2'b10, 5'd0, 5'd0, 64'sd262144);
    check("cbz_ovf_valid", 64'(bus.out_valid), 64'd0);
    check("cbz_ovf_err",   64'(bus.range_err), 64'd1);
    check("cbz_ovf_ready", 64'(bus.in_ready),  64'd1);

    // STUR 255 takes the last address; wrapped rises afterwards
    send(2'b01, 5'd5, 5'd6, 64'sd255);
    expect_word("stur_255", 32'hF80FF0C5, 2'd3);
    check("wrap_after_4", 64'(bus.wrapped), 64'd1);

    // STUR 256 and reserved op: dropped, address not advanced
    send(2'b01, 5'd5, 5'd6, 64'sd256);
    check("stur_ovf_valid", 64'(bus.out_valid), 64'd0);
    send(2'b11, 5'd1, 5'd1, 64'sd0);
    check("rsvd_valid", 64'(bus.out_valid), 64'd0);
    check("rsvd_err",   64'(bus.range_err), 64'd1);
    send(2'b00, 5'd0, 5'd0, -64'sd256);
    expect_word("ldur_min", 32'hF8500000, 2'd0);
    send(2'b00, 5'd0, 5'd0, -64'sd257);
    check("ldur_m257_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: two words fill the FIFO, the third waits
    do_reset(2);
    check("bp_rst_err", 64'(bus.range_err), 64'd0);
    bus.out_ready = 1'b0;
    send(2'b00, 5'd1, 5'd2, -64'sd8);
    send(2'b10, 5'd3, 5'd0, 64'sd5);
    check("bp_full_ready", 64'(bus.in_ready), 64'd0);
    drive(2'b01, 5'd5, 5'd6, 64'sd255);
    tick(); tick(); tick();
    check("bp_hold_ready", 64'(bus.in_ready),  64'd0);
    check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    check("bp_hold_instr", 64'(bus.out_instr), 64'hF85F8041);
    check("bp_hold_addr",  64'(bus.out_addr),  64'd0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_w1_instr", 64'(bus.out_instr), 64'hB40000A3);
    check("bp_w1_addr",  64'(bus.out_addr),  64'd1);
    check("bp_w1_ready", 64'(bus.in_ready),  64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_w2_valid", 64'(bus.out_valid), 64'd1);
    check("bp_w2_instr", 64'(bus.out_instr), 64'hF80FF0C5);
    check("bp_w2_addr",  64'(bus.out_addr),  64'd2);
    tick();
    check("bp_empty_valid", 64'(bus.out_valid), 64'd0);
    check("bp_empty_instr", 64'(bus.out_instr), 64'd0);

    // Reset mid-stream with a handshake pending
    send(2'b11, 5'd0, 5'd0, 64'sd0);
    bus.out_ready = 1'b0;
    send(2'b00, 5'd0, 5'd0, -64'sd256);
    send(2'b10, 5'd3, 5'd0, 64'sd5);
    check("mid_wrapped", 64'(bus.wrapped),   64'd1);
    check("mid_err",     64'(bus.range_err), 64'd1);
    check("mid_instr",   64'(bus.out_instr), 64'hF8500000);
    check("mid_addr",    64'(bus.out_addr),  64'd3);
    drive(2'b00, 5'd1, 5'd2, -64'sd8);
    bus.out_ready = 1'b1;
    do_reset(1);
    bus.in_valid = 1'b0;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_ready", 64'(bus.in_ready),  64'd1);
    check("mid_rst_err",   64'(bus.range_err), 64'd0);
    check("mid_rst_wrap",  64'(bus.wrapped),   64'd0);
    check("mid_rst_instr", 64'(bus.out_instr), 64'd0);
    send(2'b10, 5'd3, 5'd0, 64'sd5);
    expect_word("post_rst", 32'hB40000A3, 2'd0);
    exp_addr = 2'd1;

    // Random legal stream at one word per cycle; field must sign-extend to imm
    bus.out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 2));
      r_rt = 5'($urandom_range(0, 31));
      r_rn = 5'($urandom_range(0, 31));
      if (r_op == 2'b10) r_imm = longint'($urandom_range(0, 524287)) - 64'sd262144;
      else               r_imm = longint'($urandom_range(0, 511)) - 64'sd256;
      drive(r_op, r_rt, r_rn, r_imm);
      tick();
      check("rand_valid", 64'(bus.out_valid), 64'd1);
      check("rand_addr",  64'(bus.out_addr),  64'(exp_addr));
      check("rand_rt",    64'(bus.out_instr[4:0]), 64'(r_rt));
      if (r_op == 2'b10) begin
        cb_f = bus.out_instr[23:5];
        got  = cb_f;
        check("rand_cb_opc", 64'(bus.out_instr[31:24]), 64'hB4);
      end else begin
        dt_f = bus.out_instr[20:12];
        got  = dt_f;
        check("rand_dt_opc", 64'(bus.out_instr[31:21]), (r_op == 2'b00) ? 64'h7C2 : 64'h7C0);
        check("rand_rn",     64'(bus.out_instr[9:5]),   64'(r_rn));
      end
      check("rand_sext", got, r_imm);
      exp_addr = exp_addr + 2'd1;
    end
    bus.in_valid = 1'b0;
    tick();
    check("rand_drain", 64'(bus.out_valid), 64'd0);
    check("rand_wrap",  64'(bus.wrapped),   64'd1);
    check("rand_err",   64'(bus.range_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
